// File: rtl/freq_gen_multi.sv
// rtl/freq_gen_multi.sv - multi-channel PWM/tick generator with shadowed per-channel config
// Optional build macro: FREQ_GEN_MULTI_SYNC_EN adds sync_in to realign all enabled channels.
module freq_gen_multi #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_HIGH   = 5,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef FREQ_GEN_MULTI_SYNC_EN
    input  logic              sync_in,
`endif
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] q,
    output logic [NUM_CH-1:0] tick
);

    logic [CNT_W-1:0]  cnt_q     [NUM_CH];
    logic [CNT_W-1:0]  cnt_d     [NUM_CH];
    logic [CNT_W-1:0]  per_q     [NUM_CH];
    logic [CNT_W-1:0]  per_d     [NUM_CH];
    logic [CNT_W-1:0]  high_q    [NUM_CH];
    logic [CNT_W-1:0]  high_d    [NUM_CH];
    logic [CNT_W-1:0]  sh_per_q  [NUM_CH];
    logic [CNT_W-1:0]  sh_per_d  [NUM_CH];
    logic [CNT_W-1:0]  sh_high_q [NUM_CH];
    logic [CNT_W-1:0]  sh_high_d [NUM_CH];
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] q_q, q_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    logic              sync_c;
    logic              wr;
    logic [CNT_W-1:0]  wr_period;

`ifdef FREQ_GEN_MULTI_SYNC_EN
    assign sync_c = sync_in;
`else
    assign sync_c = 1'b0;
`endif

    always_comb begin
        cfg_ready = 1'b0;
        if (int'(cfg_ch) < NUM_CH) begin
            cfg_ready = !pending_q[cfg_ch];
        end
    end

    assign wr        = cfg_valid && cfg_ready;
    assign wr_period = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;

    always_comb begin
        logic wrap_c;
        logic apply_c;
        cnt_d     = cnt_q;
        per_d     = per_q;
        high_d    = high_q;
        sh_per_d  = sh_per_q;
        sh_high_d = sh_high_q;
        pending_d = pending_q;
        run_d     = en;
        q_d       = '0;
        tick_d    = '0;
        wrap_c    = 1'b0;
        apply_c   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            // run_q gates the wrap so the first enabled cycle always starts at cnt=0
            wrap_c  = run_q[i] && (cnt_q[i] == per_q[i] - CNT_W'(1));
            apply_c = pending_q[i] && (!en[i] || wrap_c || sync_c);
            if (apply_c) begin
                per_d[i]     = sh_per_q[i];
                high_d[i]    = sh_high_q[i];
                pending_d[i] = 1'b0;
            end
            if (!en[i] || !run_q[i] || wrap_c || sync_c) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            q_d[i]    = en[i] && (cnt_d[i] < high_d[i]);
            tick_d[i] = en[i] && (cnt_d[i] == per_d[i] - CNT_W'(1));
            // ready is low while pending, so a write never collides with an apply
            if (wr && (cfg_ch == CH_W'(i))) begin
                sh_per_d[i]  = wr_period;
                sh_high_d[i] = cfg_high;
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                per_q[i]     <= CNT_W'(DEF_PERIOD);
                high_q[i]    <= CNT_W'(DEF_HIGH);
                sh_per_q[i]  <= CNT_W'(DEF_PERIOD);
                sh_high_q[i] <= CNT_W'(DEF_HIGH);
            end
            pending_q <= '0;
            run_q     <= '0;
            q_q       <= '0;
            tick_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            high_q    <= high_d;
            sh_per_q  <= sh_per_d;
            sh_high_q <= sh_high_d;
            pending_q <= pending_d;
            run_q     <= run_d;
            q_q       <= q_d;
            tick_q    <= tick_d;
        end
    end

    assign pending = pending_q;
    assign q       = q_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_freq_gen_multi.sv
// tb/tb_freq_gen_multi.sv - randomized scoreboard bench for freq_gen_multi
module tb_freq_gen_multi;

    localparam int NCH   = 4;
    localparam int CW    = 16;
    localparam int DEF_P = 10;
    localparam int DEF_H = 5;

    typedef struct packed {
        logic [NCH-1:0] q;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] pend;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_period;
    logic [CW-1:0]  cfg_high;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] q;
    logic [NCH-1:0] tick;
`ifdef FREQ_GEN_MULTI_SYNC_EN
    logic           sync_in;
`endif

    freq_gen_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_PERIOD(DEF_P), .DEF_HIGH(DEF_H)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef FREQ_GEN_MULTI_SYNC_EN
        .sync_in    (sync_in),
`endif
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .pending    (pending),
        .q          (q),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   cfg_hold = 0;

    // Model: position within the current period (-1 when idle) plus active/shadow config.
    int m_pos  [NCH];
    int m_per  [NCH];
    int m_hi   [NCH];
    int m_sper [NCH];
    int m_shi  [NCH];
    bit m_pend [NCH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        bit   sy;
        bit   at_end;
        bit   acc;
        e  = '0;
        sy = 1'b0;
`ifdef FREQ_GEN_MULTI_SYNC_EN
        sy = sync_in;
`endif
        if (reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_pos[i] = -1; m_per[i] = DEF_P; m_hi[i] = DEF_H; m_pend[i] = 0;
            end
            cfg_hold = 0;
        end else begin
            acc = cfg_valid && !m_pend[cfg_ch];
            for (int i = 0; i < NCH; i++) begin
                at_end = (m_pos[i] == m_per[i] - 1);
                if (m_pend[i] && (!en[i] || at_end || sy)) begin
                    m_per[i] = m_sper[i]; m_hi[i] = m_shi[i]; m_pend[i] = 0;
                end
                if (!en[i]) m_pos[i] = -1;
                else if (m_pos[i] < 0 || at_end || sy) m_pos[i] = 0;
                else m_pos[i] = m_pos[i] + 1;
                e.q[i]    = en[i] && (m_pos[i] < m_hi[i]);
                e.tick[i] = en[i] && (m_pos[i] == m_per[i] - 1);
            end
            if (acc) begin
                m_sper[cfg_ch] = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
                m_shi[cfg_ch]  = int'(cfg_high);
                m_pend[cfg_ch] = 1;
            end
            cfg_hold = cfg_valid && !acc;
            for (int i = 0; i < NCH; i++) e.pend[i] = m_pend[i];
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_inputs();
        reset_n = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 39) == 0) en = en ^ (NCH'(1) << $urandom_range(0, NCH - 1));
        if (!cfg_hold) begin
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = 2'($urandom_range(0, NCH - 1));
            cfg_period = CW'($urandom_range(0, 12));
            cfg_high   = CW'($urandom_range(0, 13));
        end
`ifdef FREQ_GEN_MULTI_SYNC_EN
        sync_in = ($urandom_range(0, 59) == 0);
`endif
    endtask

    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                chk("q", 32'(q), 32'(ex.q));
                chk("tick", 32'(tick), 32'(ex.tick));
                chk("pending", 32'(pending), 32'(ex.pend));
                chk("cfg_ready", 32'(cfg_ready), 32'(!ex.pend[cfg_ch]));
            end
        end
    end

    initial begin
        reset_n    = 1'b1;
        en         = '0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_high   = '0;
`ifdef FREQ_GEN_MULTI_SYNC_EN
        sync_in    = 1'b0;
`endif
        for (int i = 0; i < NCH; i++) begin
            m_pos[i] = -1; m_per[i] = DEF_P; m_hi[i] = DEF_H;
            m_sper[i] = DEF_P; m_shi[i] = DEF_H; m_pend[i] = 0;
        end
        #2;
        repeat (2) step();
        reset_n = 1'b0;
        en      = '1;
        repeat (40) step();
        // Mid-period reconfiguration of ch0, then a back-to-back write to ch1.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_period = CW'(4); cfg_high = CW'(1);
        step();
        cfg_ch = 2'd1; cfg_period = CW'(3); cfg_high = CW'(2);
        step();
        cfg_period = CW'(7); cfg_high = CW'(3);
        repeat (30) begin
            if (!cfg_hold) cfg_valid = 1'b0;
            step();
        end
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_period = CW'(0); cfg_high = CW'(7);
        step();
        repeat (20) begin
            if (!cfg_hold) begin cfg_period = CW'(6); cfg_high = CW'(0); end
            step();
        end
        cfg_valid = 1'b0;
        repeat (20) step();
        repeat (4000) begin
            rand_inputs();
            step();
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: got %0d entries left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/freq_gen_multi.md
Name: freq_gen_multi

Overview:
- Parametrised, multi-channel successor to the single-output frequency generator.
- Each channel produces a square/PWM output `q` with a runtime-programmable period and high time, plus a one-cycle `tick` at each period wrap.
- Configuration is written through a valid/ready port and held in a per-channel shadow register. It takes effect only at the channel's period boundary, so outputs never glitch.
- Used as the clock-enable / test-waveform source for downstream blocks.

Parameters:
- NUM_CH, 4: number of independent output channels (1..16).
- CNT_W, 16: width of the period, high-time and counter fields.
- DEF_PERIOD, 10: active period loaded at reset. Must be >= 2.
- DEF_HIGH, 5: active high time loaded at reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-high reset (1 = reset), sampled on rising clk.
- en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  channel addressed by cfg_ch can accept a write.
- cfg_ch  in  clog2(NUM_CH) (min 1)  target channel.
- cfg_period  in  CNT_W  new period in cycles.
- cfg_high  in  CNT_W  new high time in cycles.
- pending  out  NUM_CH  shadow config waiting to be applied.
- q  out  NUM_CH  waveform outputs, registered.
- tick  out  NUM_CH  one-cycle pulse at the last cycle of each period, registered.

Behaviour:
- Reset (reset_n=1 at a clk edge), taking priority over everything:
  - per-channel cnt=0, period=DEF_PERIOD, high=DEF_HIGH.
  - pending=0, q=0, tick=0.
  - Any write presented in the reset cycle is discarded.
  - Reset mid-period aborts the period immediately.
- Channel counter while en=1:
  - cnt increments each cycle and wraps from period-1 to 0.
  - q = (cnt < high), aligned with cnt (registered from next-cnt logic).
  - tick = (cnt == period-1).
  - Latency from en rising at edge E: at edge E+1, cnt=0, q=(0<high), tick=0.
- en=0:
  - Next edge sets cnt=0, q=0, tick=0 and holds them.
  - A pending config is applied at that edge.
- Handshake:
  - cfg_ready = !pending[cfg_ch] (combinational).
  - A write occurs when cfg_valid && cfg_ready at a rising edge. It stores cfg_period/cfg_high in the shadow and sets pending[cfg_ch].
  - With cfg_valid=1 and ready=0, the master must hold its data. There is no overwrite.
- Apply:
  - Shadow is copied to active at the edge where the counter wraps (cnt==period-1 → 0), or at the next edge if the channel is disabled. pending clears on the same edge.
  - The new values govern from cnt=0 onward.
  - A write and an apply on the same channel in the same cycle cannot occur, since ready is low while pending.
- Clamping, applied at write time and visible in the shadow:
  - cfg_period < 2 → period = 2.
  - cfg_high >= period → q constant 1 while enabled.
  - cfg_high = 0 → q constant 0. tick still pulses.
- All channels are independent. Simultaneous wraps on different channels are all honoured.
- All arithmetic is unsigned, CNT_W bits. The counter never exceeds period-1.

Optional Feature:
- Macro: FREQ_GEN_MULTI_SYNC_EN.
- When defined:
  - Adds input port sync_in (1 bit).
  - sync_in=1 at an edge forces cnt=0 on every enabled channel and applies any pending config as if the channel had wrapped.
  - tick is not generated for the truncated period.
  - q is aligned to cnt=0 on the following cycle.
  - reset_n has priority over sync_in. sync_in has priority over a normal wrap.
- When undefined: port sync_in is absent and no sync logic is generated.

Test Plan:
- Reset defaults:
  - Stimulus: hold reset_n=1 for 2 cycles, release, set en=all-ones.
  - Required: q=0, tick=0 and pending=0 during reset. Afterwards each q is 5 high, 5 low, repeating, and tick pulses every 10 cycles at cnt=9.
- Period change at boundary:
  - Stimulus: ch0 running 10/5; write period=4, high=1 mid-period.
  - Required: pending[0]=1 until the wrap. The old period completes intact, then q[0]=1,0,0,0 repeating and pending[0] clears at the wrap edge.
- Backpressure:
  - Stimulus: second write to ch1 while pending[1]=1.
  - Required: cfg_ready=0. The write is accepted only on the cycle after the apply, and its values take effect at the following wrap.
- Clamp/edge values:
  - Stimulus: write period=0, high=7 to ch2; then period=6, high=0.
  - Required: first config gives period 2 with q constant 1. Second gives q constant 0 with tick every 6 cycles.
- Disable/reset mid-operation:
  - Stimulus: drop en[3] at cnt=3; later assert reset_n at cnt=2 of a 10-cycle period.
  - Required: q[3]=0 and cnt=0 on the next edge, with any pending config applied. Reset returns period/high to 10/5 and q=0 on the next edge.
- Sync (FREQ_GEN_MULTI_SYNC_EN defined):
  - Stimulus: channels at different phases with periods 10 and 4; pulse sync_in.
  - Required: both channels show cnt=0 on the next edge, no tick in that cycle, and their q waveforms are phase-aligned afterwards.
